// File: rtl/adma_pkg.sv
// ADMA shared encodings: controller states, descriptor actions and fetch constants.
// Used by the descriptor fetch unit and the state transition FSM.
package adma_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_FDS  = 2'b01,
        ST_CADR = 2'b10,
        ST_TFR  = 2'b11
    } adma_st_e;

    localparam logic [1:0] ACT_NOP  = 2'b00;
    localparam logic [1:0] ACT_RSV  = 2'b01;
    localparam logic [1:0] ACT_TRAN = 2'b10;
    localparam logic [1:0] ACT_LINK = 2'b11;

    localparam logic [31:0] DESC_STRIDE = 32'd8;
    localparam logic [7:0]  TIMEOUT_MAX = 8'd255;

    typedef enum logic [2:0] {
        F_IDLE,
        F_REQ_LO,
        F_REQ_HI,
        F_DECODE,
        F_ABORT
    } fetch_st_e;

    typedef struct packed {
        logic [15:0] len;
        logic [1:0]  act;
        logic        intr;
        logic        endd;
        logic        valid;
    } desc_lo_t;

endpackage

// File: rtl/adma_descriptor_fetch_if.sv
// Descriptor memory read channel: request held until acknowledged,
// data valid in the acknowledge cycle.
interface adma_descriptor_fetch_if;
    import adma_pkg::*;

    logic        Rd_Req;
    logic [31:0] Rd_Addr;
    logic        Rd_Ack;
    logic [31:0] Rd_Data;

    modport master (
        output Rd_Req,
        output Rd_Addr,
        input  Rd_Ack,
        input  Rd_Data
    );

    modport slave (
        input  Rd_Req,
        input  Rd_Addr,
        output Rd_Ack,
        output Rd_Data
    );

endinterface

// File: rtl/adma_descriptor_fetch.sv
// ADMA descriptor fetch: reads two-word descriptors and tracks the table pointer.
// Define ADMA_FETCH_TIMEOUT_EN to abandon reads unacknowledged for 255 cycles.
module adma_descriptor_fetch
    import adma_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  EstadoActual,
    input  logic        Sys_Addr_Load,
    input  logic [31:0] Sys_Addr,
    adma_descriptor_fetch_if.master rd,
    output logic        Valid,
    output logic        End,
    output logic        Tran,
    output logic        Link,
    output logic        Int,
    output logic [31:0] Desc_Addr,
    output logic [15:0] Desc_Length,
    output logic        Desc_Ready,
    output logic [31:0] Desc_Ptr,
    output logic        Fetch_Error
);

    fetch_st_e state, state_n;
    adma_st_e  est;
    desc_lo_t  lo_q;

    logic        fds_q, cadr_q;
    logic        fds_edge, cadr_edge, stop;
    logic        rd_req_q, rd_req_n;
    logic [31:0] rd_addr_q;
    logic        start, lo_take, hi_take;
    logic        ptr_cadr, ptr_load;
    logic        tmo_hit;
    logic        unused_bits;

    assign est       = adma_st_e'(EstadoActual);
    assign stop      = (est == ST_STOP);
    assign fds_edge  = (est == ST_FDS) && !fds_q;
    assign cadr_edge = (est == ST_CADR) && !cadr_q;

    // Pointer moves only while no fetch is in flight
    assign ptr_cadr = cadr_edge && (state == F_IDLE || state == F_DECODE);
    assign ptr_load = Sys_Addr_Load && stop && (state == F_IDLE);

    assign rd.Rd_Req    = rd_req_q;
    assign rd.Rd_Addr   = rd_addr_q;
    assign unused_bits  = ^{rd.Rd_Data[15:6], rd.Rd_Data[3]};

`ifdef ADMA_FETCH_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    assign tmo_hit = rd_req_q && !rd.Rd_Ack &&
                     (wait_cnt == TIMEOUT_MAX - 8'd1);
    assign Fetch_Error = err_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (rd_req_q && !rd.Rd_Ack && !tmo_hit)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= 8'd0;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign Fetch_Error = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) state <= F_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        rd_req_n = rd_req_q;
        start    = 1'b0;
        lo_take  = 1'b0;
        hi_take  = 1'b0;
        unique case (state)
            F_IDLE: begin
                if (fds_edge) begin
                    state_n  = F_REQ_LO;
                    rd_req_n = 1'b1;
                    start    = 1'b1;
                end
            end
            F_REQ_LO, F_REQ_HI: begin
                if (stop) begin
                    if (rd.Rd_Ack) begin
                        state_n  = F_IDLE;
                        rd_req_n = 1'b0;
                    end else begin
                        state_n = F_ABORT;
                    end
                end else if (rd.Rd_Ack) begin
                    if (state == F_REQ_LO) begin
                        state_n = F_REQ_HI;
                        lo_take = 1'b1;
                    end else begin
                        state_n  = F_DECODE;
                        rd_req_n = 1'b0;
                        hi_take  = 1'b1;
                    end
                end
            end
            F_DECODE: state_n = F_IDLE;
            F_ABORT: begin
                if (rd.Rd_Ack) begin
                    state_n  = F_IDLE;
                    rd_req_n = 1'b0;
                end
            end
            default: state_n = F_IDLE;
        endcase
        if (tmo_hit) begin
            state_n  = F_IDLE;
            rd_req_n = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fds_q       <= 1'b0;
            cadr_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= 32'd0;
            lo_q        <= '0;
            Valid       <= 1'b0;
            End         <= 1'b0;
            Tran        <= 1'b0;
            Link        <= 1'b0;
            Int         <= 1'b0;
            Desc_Addr   <= 32'd0;
            Desc_Length <= 16'd0;
            Desc_Ready  <= 1'b0;
            Desc_Ptr    <= 32'd0;
        end else begin
            fds_q    <= (est == ST_FDS);
            cadr_q   <= (est == ST_CADR);
            rd_req_q <= rd_req_n;
            if (start) begin
                rd_addr_q   <= Desc_Ptr;
                Valid       <= 1'b0;
                End         <= 1'b0;
                Tran        <= 1'b0;
                Link        <= 1'b0;
                Int         <= 1'b0;
                Desc_Addr   <= 32'd0;
                Desc_Length <= 16'd0;
                Desc_Ready  <= 1'b0;
            end
            if (lo_take) begin
                lo_q      <= {rd.Rd_Data[31:16], rd.Rd_Data[5:4],
                              rd.Rd_Data[2:0]};
                rd_addr_q <= Desc_Ptr + 32'd4;
            end
            if (hi_take) begin
                Valid       <= lo_q.valid;
                End         <= lo_q.endd;
                Int         <= lo_q.intr;
                Tran        <= (lo_q.act == ACT_TRAN);
                Link        <= (lo_q.act == ACT_LINK);
                Desc_Length <= lo_q.len;
                Desc_Addr   <= rd.Rd_Data;
                Desc_Ready  <= 1'b1;
            end
            if (tmo_hit) begin
                Valid      <= 1'b0;
                Desc_Ready <= 1'b1;
            end
            if (ptr_cadr) begin
                Desc_Ptr   <= Link ? {Desc_Addr[31:3], 3'b000}
                                   : Desc_Ptr + DESC_STRIDE;
                Desc_Ready <= 1'b0;
            end else if (ptr_load) begin
                Desc_Ptr   <= {Sys_Addr[31:3], 3'b000};
                Desc_Ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adma_descriptor_fetch.sv
// Scoreboard bench for adma_descriptor_fetch with a randomized-latency memory.
// Define ADMA_FETCH_TIMEOUT_EN to also exercise the read timeout.
module tb_adma_descriptor_fetch;
    import adma_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  EstadoActual;
    logic        Sys_Addr_Load;
    logic [31:0] Sys_Addr;
    logic        Valid, End, Tran, Link, Int;
    logic [31:0] Desc_Addr, Desc_Ptr;
    logic [15:0] Desc_Length;
    logic        Desc_Ready, Fetch_Error;

    adma_descriptor_fetch_if bus();

    adma_descriptor_fetch dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .EstadoActual  (EstadoActual),
        .Sys_Addr_Load (Sys_Addr_Load),
        .Sys_Addr      (Sys_Addr),
        .rd            (bus),
        .Valid         (Valid),
        .End           (End),
        .Tran          (Tran),
        .Link          (Link),
        .Int           (Int),
        .Desc_Addr     (Desc_Addr),
        .Desc_Length   (Desc_Length),
        .Desc_Ready    (Desc_Ready),
        .Desc_Ptr      (Desc_Ptr),
        .Fetch_Error   (Fetch_Error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        v, e, t, l, i;
        logic [31:0] addr;
        logic [15:0] len;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] mem[logic [31:0]];

    int n_vec = 0;
    int n_err = 0;
    int force_wait = -1;
    int ack_count = 0;
    int err_pulses = 0;
    int exp_err = 0;

    logic [31:0] mptr = 32'd0;
    logic        last_link = 1'b0;
    logic [31:0] last_hi = 32'd0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] lo, input logic [31:0] hi);
        exp_t r;
        r.v    = lo[0];
        r.e    = lo[1];
        r.i    = lo[2];
        r.t    = (lo[5:4] == 2'b10);
        r.l    = (lo[5:4] == 2'b11);
        r.addr = hi;
        r.len  = lo[31:16];
        return r;
    endfunction

    // Memory responder and request-address monitor
    bit          beat_on = 0;
    int          wcnt = 0;
    int          cur_wait = 0;
    logic [31:0] beat_addr;

    always @(negedge CLK) begin
        if (RESET !== 1'b0 || bus.Rd_Req !== 1'b1) begin
            bus.Rd_Ack = 1'b0;
            beat_on = 0;
        end else begin
            if (!beat_on) begin
                beat_on = 1;
                wcnt = 0;
                beat_addr = bus.Rd_Addr;
                cur_wait = (force_wait >= 0) ? force_wait
                                             : int'($urandom_range(0, 2));
            end
            if (wcnt >= cur_wait) begin
                bus.Rd_Ack = 1'b1;
                bus.Rd_Data = mem.exists(bus.Rd_Addr) ? mem[bus.Rd_Addr] : 32'h0;
                beat_on = 0;
                ack_count++;
                check("rd_addr_stable", bus.Rd_Addr, beat_addr);
                if (addr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rd_addr actual=%h required=no read", bus.Rd_Addr);
                end else begin
                    check("rd_addr", bus.Rd_Addr, addr_q.pop_front());
                end
            end else begin
                bus.Rd_Ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Decoded-descriptor monitor
    logic rdy_prev = 1'b0;
    exp_t em;

    always @(negedge CLK) begin
        if (RESET === 1'b0 && Desc_Ready === 1'b1 && !rdy_prev) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL desc_ready actual=rise required=no descriptor");
            end else begin
                em = exp_q.pop_front();
                check("valid", Valid, em.v);
                check("end", End, em.e);
                check("tran", Tran, em.t);
                check("link", Link, em.l);
                check("int", Int, em.i);
                check("desc_addr", Desc_Addr, em.addr);
                check("desc_len", Desc_Length, em.len);
            end
        end
        rdy_prev = (RESET === 1'b0) ? Desc_Ready : 1'b0;
        if (Fetch_Error === 1'b1) err_pulses++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [31:0] a);
        EstadoActual  = ST_STOP;
        Sys_Addr      = a;
        Sys_Addr_Load = 1'b1;
        tick();
        Sys_Addr_Load = 1'b0;
        mptr = {a[31:3], 3'b000};
        check("load_ptr", Desc_Ptr, mptr);
    endtask

    task automatic do_fetch(input logic [31:0] lo, input logic [31:0] hi,
                            input bit chk_lat);
        int n;
        mem[mptr] = lo;
        mem[mptr + 32'd4] = hi;
        addr_q.push_back(mptr);
        addr_q.push_back(mptr + 32'd4);
        exp_q.push_back(model(lo, hi));
        last_link = (lo[5:4] == 2'b11);
        last_hi = hi;
        EstadoActual = ST_FDS;
        n = 0;
        do begin
            tick();
            n++;
        end while (Desc_Ready !== 1'b1 && n < 60);
        if (Desc_Ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL fetch_done actual=timeout required=Desc_Ready");
        end else if (chk_lat) begin
            check("latency", n, 3);
        end
        EstadoActual = ST_TFR;
        tick();
    endtask

    task automatic do_cadr();
        EstadoActual = ST_CADR;
        tick();
        mptr = last_link ? {last_hi[31:3], 3'b000} : mptr + 32'd8;
        check("cadr_ptr", Desc_Ptr, mptr);
        check("cadr_ready", Desc_Ready, 1'b0);
        EstadoActual = ST_TFR;
        tick();
    endtask

    task automatic abort_test();
        logic [31:0] old;
        int a0;
        old = mptr;
        mem[mptr] = $urandom();
        mem[mptr + 32'd4] = $urandom();
        addr_q.push_back(mptr);
        force_wait = 3;
        a0 = ack_count;
        EstadoActual = ST_FDS;
        tick();
        EstadoActual  = ST_STOP;
        Sys_Addr      = 32'hDEAD_0000;
        Sys_Addr_Load = 1'b1;
        tick();
        Sys_Addr_Load = 1'b0;
        repeat (8) tick();
        check("abort_acks", ack_count - a0, 1);
        check("abort_ready", Desc_Ready, 1'b0);
        check("abort_ptr", Desc_Ptr, old);
        check("abort_rdreq", bus.Rd_Req, 1'b0);
        check("abort_no_hi", addr_q.size(), 0);
        force_wait = -1;
    endtask

`ifdef ADMA_FETCH_TIMEOUT_EN
    task automatic timeout_test();
        int hi_cnt;
        int e0;
        exp_t z;
        z = model(32'h0, 32'h0);
        exp_q.push_back(z);
        e0 = err_pulses;
        force_wait = 100000;
        EstadoActual = ST_FDS;
        hi_cnt = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (bus.Rd_Req === 1'b1) hi_cnt++;
            else if (hi_cnt > 0) break;
        end
        check("tmo_cycles", hi_cnt, 255);
        repeat (3) tick();
        check("tmo_pulses", err_pulses - e0, 1);
        check("tmo_valid", Valid, 1'b0);
        check("tmo_ready", Desc_Ready, 1'b1);
        exp_err = 1;
        force_wait = -1;
        EstadoActual = ST_TFR;
        tick();
    endtask
`endif

    initial begin
        logic [31:0] lo;
        bus.Rd_Ack    = 1'b0;
        bus.Rd_Data   = 32'h0;
        RESET         = 1'b1;
        EstadoActual  = ST_FDS;
        Sys_Addr_Load = 1'b1;
        Sys_Addr      = 32'h1234_5678;
        repeat (3) tick();
        check("rst_ptr", Desc_Ptr, 32'h0);
        check("rst_rdreq", bus.Rd_Req, 1'b0);
        check("rst_rdaddr", bus.Rd_Addr, 32'h0);
        check("rst_ready", Desc_Ready, 1'b0);
        check("rst_attr", {Valid, End, Tran, Link, Int}, 5'b0);
        check("rst_daddr", Desc_Addr, 32'h0);
        check("rst_len", Desc_Length, 16'h0);
        check("rst_ferr", Fetch_Error, 1'b0);
        EstadoActual  = ST_STOP;
        Sys_Addr_Load = 1'b0;
        RESET = 1'b0;
        tick();

        do_load(32'h0000_1004);
        force_wait = 0;
        do_fetch(32'h0200_0023, 32'h8000_0000, 1'b1);
        force_wait = -1;
        do_cadr();
        do_fetch($urandom(), $urandom(), 1'b0);
        do_fetch(32'h0000_0031, 32'h0000_2005, 1'b0);
        do_cadr();

        do_load(32'hFFFF_FFF8);
        lo = $urandom();
        lo[5:4] = 2'b10;
        do_fetch(lo, $urandom(), 1'b0);
        do_cadr();

        abort_test();

        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 3) == 0) do_load($urandom());
            do_fetch($urandom(), $urandom(), 1'b0);
            do_cadr();
        end

`ifdef ADMA_FETCH_TIMEOUT_EN
        timeout_test();
`endif

        repeat (5) tick();
        check("exp_q_empty", exp_q.size(), 0);
        check("addr_q_empty", addr_q.size(), 0);
        check("ferr_pulses", err_pulses, exp_err);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
